// File: rtl/conv_operand_deser_pkg.sv
// Shared convolutor definitions: operand width, deserialiser states and the
// saturating error-counter helper.
package conv_pkg;

  localparam int unsigned OPERAND_W = 6;
  localparam int unsigned ERR_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } deser_state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/conv_operand_deser_shift.sv
// Right-shift-in operand register: new bits enter at the MSB, so after WIDTH
// shifts the first bit received sits in bit 0.
module deser_shift
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH = OPERAND_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_i,
  input  logic             shift_en_i,
  input  logic             restart_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // A restart drops any partial word and makes the incoming bit the new bit 0.
  always_comb begin
    shift_d = shift_q;
    if (shift_en_i) begin
      if (restart_i) shift_d = {bit_i, {(WIDTH-1){1'b0}}};
      else           shift_d = {bit_i, shift_q[WIDTH-1:1]};
    end else if (restart_i) begin
      shift_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) shift_q <= '0;
    else         shift_q <= shift_d;
  end

  assign q_o = shift_q;

endmodule

// File: rtl/conv_operand_deser.sv
// Bit-serial operand receiver: reassembles LSB-first (a_bit, b_bit) beats into
// parallel operand pairs and flags start-of-frame violations.
module conv_operand_deser
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH = OPERAND_W,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic                 a_bit,
  input  logic                 b_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     A_out,
  output logic [WIDTH-1:0]     B_out,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  deser_state_t         state_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [WIDTH-1:0]     a_word_q;
  logic [WIDTH-1:0]     b_word_q;
  logic                 out_valid_q;
  logic                 frame_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic             accept;
  logic             shift_en;
  logic             restart;
  logic             last_beat;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             unused_lsbs;

  // While holding a word, a new beat may only enter in the cycle the word leaves.
  assign in_ready  = (state_q == HOLD) ? out_ready : 1'b1;
  assign accept    = in_valid & in_ready;
  assign restart   = accept & in_sof;
  assign shift_en  = accept & (in_sof | (state_q == SHIFT));
  assign last_beat = (bit_cnt_q == CNT_W'(WIDTH - 1));

  deser_shift #(.WIDTH(WIDTH)) u_shift_a (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .bit_i      (a_bit),
    .shift_en_i (shift_en),
    .restart_i  (restart),
    .q_o        (sh_a)
  );

  deser_shift #(.WIDTH(WIDTH)) u_shift_b (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .bit_i      (b_bit),
    .shift_en_i (shift_en),
    .restart_i  (restart),
    .q_o        (sh_b)
  );

  // Bit 0 of the shift registers is pushed out by the completing beat.
  assign unused_lsbs = sh_a[0] ^ sh_b[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      a_word_q    <= '0;
      b_word_q    <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (in_sof) begin
              state_q   <= SHIFT;
              bit_cnt_q <= CNT_W'(1);
            end else begin
              frame_err_q <= 1'b1;
              err_cnt_q   <= sat_inc(err_cnt_q);
            end
          end
        end
        SHIFT: begin
          if (accept) begin
            if (in_sof) begin
              frame_err_q <= 1'b1;
              err_cnt_q   <= sat_inc(err_cnt_q);
              bit_cnt_q   <= CNT_W'(1);
            end else if (last_beat) begin
              a_word_q    <= {a_bit, sh_a[WIDTH-1:1]};
              b_word_q    <= {b_bit, sh_b[WIDTH-1:1]};
              bit_cnt_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept && in_sof) begin
              state_q   <= SHIFT;
              bit_cnt_q <= CNT_W'(1);
            end else begin
              state_q <= IDLE;
              if (accept) begin
                frame_err_q <= 1'b1;
                err_cnt_q   <= sat_inc(err_cnt_q);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign A_out     = a_word_q;
  assign B_out     = b_word_q;
  assign frame_err = frame_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_conv_operand_deser.sv
// Scoreboard bench for conv_operand_deser: expected word pairs are queued as
// they are sent and compared when the output handshake completes.
module tb_conv_operand_deser;

  localparam int unsigned W = 6;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_sof;
  logic         a_bit;
  logic         b_bit;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] A_out;
  logic [W-1:0] B_out;
  logic         frame_err;
  logic [3:0]   err_count;

  int checks   = 0;
  int failures = 0;
  int fe_seen  = 0;
  int fe_base;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] exp_word;

  conv_operand_deser #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_out     (A_out),
    .B_out     (B_out),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: counts frame_err pulses and scores completed handshakes.
  always @(negedge clock) begin
    if (frame_err) fe_seen++;
    if (reset_n && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_word = sb.pop_front();
        chk("word_A", 32'(A_out), 32'(exp_word[2*W-1:W]));
        chk("word_B", 32'(B_out), 32'(exp_word[W-1:0]));
      end
    end
  end

  // Sends bits first..last of a/b; gaps of 1..maxgap idle cycles precede each beat.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int first, input int last, input int maxgap);
    for (int i = first; i <= last; i++) begin
      if (maxgap > 0) begin
        repeat ($urandom_range(1, maxgap)) begin
          @(posedge clock); #1;
          in_valid = 1'b0;
        end
      end
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_sof   = (i == 0);
      a_bit    = a[i];
      b_bit    = b[i];
    end
    if (last == W - 1) begin
      @(negedge clock);
      chk("pre_valid", 32'(out_valid), 0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (last == W - 1) begin
      @(negedge clock);
      chk("lat_valid", 32'(out_valid), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_A", 32'(A_out), 0);
    chk("rst_B", 32'(B_out), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_in_ready", 32'(in_ready), 1);

    // Back-to-back word, consumer always ready
    sb.push_back({6'h2D, 6'h33});
    send_word(6'h2D, 6'h33, 0, W - 1, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("b2b_no_err", 32'(fe_seen), 0);
    chk("b2b_drained", 32'(sb.size()), 0);

    // Backpressure: word held, beats refused, then consumed with next SOF in same cycle
    out_ready = 1'b0;
    sb.push_back({6'h2D, 6'h33});
    send_word(6'h2D, 6'h33, 0, W - 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_sof   = 1'b0;
      a_bit    = 1'b1;
      b_bit    = 1'b1;
      @(negedge clock);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_A_hold", 32'(A_out), 32'h2D);
      chk("bp_B_hold", 32'(B_out), 32'h33);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sof    = 1'b1;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    sb.push_back({6'h25, 6'h12});
    @(negedge clock);
    chk("bp_release_ready", 32'(in_ready), 1);
    send_word(6'h25, 6'h12, 1, W - 1, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("bp_no_err", 32'(err_count), 0);
    chk("bp_drained", 32'(sb.size()), 0);

    // SOF arriving mid-word restarts assembly
    fe_base = fe_seen;
    send_word(6'h3F, 6'h3F, 0, 2, 0);
    sb.push_back({6'h01, 6'h01});
    send_word(6'h01, 6'h01, 0, W - 1, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("sof_mid_pulses", 32'(fe_seen - fe_base), 1);
    chk("sof_mid_err_count", 32'(err_count), 1);
    chk("sof_mid_drained", 32'(sb.size()), 0);

    // Missing SOF: isolated beats dropped, counter saturates
    fe_base = fe_seen;
    repeat (20) begin
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_sof   = 1'b0;
      a_bit    = 1'($urandom_range(0, 1));
      b_bit    = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(negedge clock);
      chk("nosof_valid", 32'(out_valid), 0);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("nosof_pulses", 32'(fe_seen - fe_base), 20);
    chk("nosof_err_sat", 32'(err_count), 15);
    chk("nosof_drained", 32'(sb.size()), 0);

    // Reset mid-word: asynchronous clear, then a clean word
    send_word(6'h3F, 6'h15, 0, 3, 0);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("amid_rst_valid", 32'(out_valid), 0);
    chk("amid_rst_A", 32'(A_out), 0);
    chk("amid_rst_B", 32'(B_out), 0);
    chk("amid_rst_err_count", 32'(err_count), 0);
    chk("amid_rst_frame_err", 32'(frame_err), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    fe_base = fe_seen;
    sb.push_back({6'h15, 6'h2A});
    send_word(6'h15, 6'h2A, 0, W - 1, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("post_rst_no_err", 32'(fe_seen - fe_base), 0);
    chk("post_rst_drained", 32'(sb.size()), 0);

    // Bubbles between beats
    for (int r = 0; r < 3; r++) begin
      sb.push_back({6'h2D, 6'h33});
      send_word(6'h2D, 6'h33, 0, W - 1, 3);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("bubble_no_err", 32'(err_count), 0);
    chk("final_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
